// File: rtl/clk_div_multi_if.sv
// Control and status bundle for clk_div_multi: per-channel enables, ratios, the sync strobe and the divided outputs.
interface clk_div_multi_if #(
    parameter int CH_NUM = 4,
    parameter int DIV_W  = 8
);
    logic [CH_NUM-1:0]       div_en;
    logic [CH_NUM*DIV_W-1:0] div_ratio;
    logic                    sync_in;
    logic [CH_NUM-1:0]       clk_out;
    logic [CH_NUM-1:0]       div_tick;
    logic [CH_NUM-1:0]       ratio_ack;

    modport master (
        output div_en, div_ratio, sync_in,
        input  clk_out, div_tick, ratio_ack
    );
    modport slave (
        input  div_en, div_ratio, sync_in,
        output clk_out, div_tick, ratio_ack
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed ratios and a global phase-align strobe.
// Optional macro CLKDIV_ODD_DUTY50_EN adds a negedge stage per channel for 50% duty on odd ratios.
module clk_div_multi #(
    parameter int CH_NUM = 4,
    parameter int DIV_W  = 8
) (
    input  logic           clk_in,
    input  logic           rst_n,
    clk_div_multi_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DIV_W:0]   ONE       = (DIV_W+1)'(1);
    localparam logic [DIV_W-1:0] MIN_RATIO = DIV_W'(2);

    state_t            state     [CH_NUM];
    state_t            state_nxt [CH_NUM];
    logic [DIV_W-1:0]  cnt       [CH_NUM];
    logic [DIV_W-1:0]  cnt_nxt   [CH_NUM];
    logic [DIV_W-1:0]  shadow    [CH_NUM];
    logic [DIV_W-1:0]  shadow_nxt[CH_NUM];
    logic [DIV_W-1:0]  req       [CH_NUM];
    logic [DIV_W:0]    n_ext     [CH_NUM];
    logic [DIV_W:0]    h_ext     [CH_NUM];
    logic [DIV_W:0]    inc       [CH_NUM];
    logic [CH_NUM-1:0] restart;
    logic [CH_NUM-1:0] clk_q, clk_nxt;
    logic [CH_NUM-1:0] tick_q, tick_nxt;
    logic [CH_NUM-1:0] ack_q, ack_nxt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                state[k]  <= IDLE;
                cnt[k]    <= '0;
                shadow[k] <= MIN_RATIO;
            end
            clk_q  <= '0;
            tick_q <= '0;
            ack_q  <= '0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                state[k]  <= state_nxt[k];
                cnt[k]    <= cnt_nxt[k];
                shadow[k] <= shadow_nxt[k];
            end
            clk_q  <= clk_nxt;
            tick_q <= tick_nxt;
            ack_q  <= ack_nxt;
        end
    end

    // Sync and IDLE-start share the wrap action; sync overrides counting and suppresses the tick.
    always_comb begin
        restart  = '0;
        clk_nxt  = '0;
        tick_nxt = '0;
        ack_nxt  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            req[k] = bus.div_ratio[k*DIV_W +: DIV_W];
            if (req[k] < MIN_RATIO) req[k] = MIN_RATIO;
            n_ext[k]      = {1'b0, shadow[k]};
            h_ext[k]      = (n_ext[k] + ONE) >> 1;
            inc[k]        = {1'b0, cnt[k]} + ONE;
            state_nxt[k]  = state[k];
            cnt_nxt[k]    = cnt[k];
            shadow_nxt[k] = shadow[k];

            if (bus.div_en[k] && (bus.sync_in || state[k] == IDLE)) begin
                restart[k] = 1'b1;
            end else if (state[k] == RUN) begin
                if (inc[k] < n_ext[k]) begin
                    cnt_nxt[k]  = inc[k][DIV_W-1:0];
                    clk_nxt[k]  = (inc[k] < h_ext[k]);
                    tick_nxt[k] = (inc[k] == n_ext[k] - ONE);
                end else if (bus.div_en[k]) begin
                    restart[k] = 1'b1;
                end else begin
                    state_nxt[k] = IDLE;
                    cnt_nxt[k]   = '0;
                end
            end else begin
                cnt_nxt[k] = '0;
            end

            if (restart[k]) begin
                state_nxt[k]  = RUN;
                cnt_nxt[k]    = '0;
                clk_nxt[k]    = 1'b1;
                shadow_nxt[k] = req[k];
                ack_nxt[k]    = (req[k] != shadow[k]);
            end
        end
    end

`ifdef CLKDIV_ODD_DUTY50_EN
    logic [CH_NUM-1:0] neg_q;

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) neg_q <= '0;
        else        neg_q <= clk_q;
    end

    // Odd ratios trim half a source cycle off the high phase by ANDing with the negedge copy.
    always_comb begin
        bus.clk_out   = clk_q;
        bus.div_tick  = tick_q;
        bus.ratio_ack = ack_q;
        for (int k = 0; k < CH_NUM; k++) begin
            if (shadow[k][0]) bus.clk_out[k] = clk_q[k] & neg_q[k];
        end
    end
`else
    always_comb begin
        bus.clk_out   = clk_q;
        bus.div_tick  = tick_q;
        bus.ratio_ack = ack_q;
    end
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected per-cycle outputs are queued from period patterns, then popped each edge.
module tb_clk_div_multi;
    localparam int CH_NUM = 4;
    localparam int DIV_W  = 8;
`ifdef CLKDIV_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] mask;
        logic [3:0] clk;
        logic [3:0] tick;
        logic [3:0] ack;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    clk_div_multi_if #(.CH_NUM(CH_NUM), .DIV_W(DIV_W)) bus ();

    clk_div_multi #(.CH_NUM(CH_NUM), .DIV_W(DIV_W)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Sampled output at posedge+1 for position pos of a period of n cycles.
    function automatic logic clk_exp(int n, int pos);
        int h;
        h = (n + 1) / 2;
        if (ODD50 && (n % 2 == 1) && pos == 0) return 1'b0;
        return (pos < h);
    endfunction

    function automatic void ensure(int idx);
        while (sb.size() <= idx) sb.push_back('0);
    endfunction

    function automatic void add_wave(int ch, int n, int start, int len, bit ack_first);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            ensure(start + i);
            e          = sb[start + i];
            e.mask[ch] = 1'b1;
            e.clk[ch]  = clk_exp(n, i % n);
            e.tick[ch] = ((i % n) == n - 1);
            e.ack[ch]  = ack_first && (i == 0);
            sb[start + i] = e;
        end
    endfunction

    function automatic void add_idle(int ch, int start, int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            ensure(start + i);
            e          = sb[start + i];
            e.mask[ch] = 1'b1;
            e.clk[ch]  = 1'b0;
            e.tick[ch] = 1'b0;
            e.ack[ch]  = 1'b0;
            sb[start + i] = e;
        end
    endfunction

    task automatic set_ratio(input int ch, input int v);
        bus.div_ratio[ch*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic do_reset();
        bus.div_en    = '0;
        bus.div_ratio = '0;
        bus.sync_in   = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Advance one edge and pop the expectation for it; comparisons stay in the callers.
    task automatic advance(output logic [11:0] got, output logic [11:0] want);
        exp_t e;
        @(posedge clk_in);
        #1;
        e    = sb.pop_front();
        got  = {bus.clk_out, bus.div_tick, bus.ratio_ack} & {3{e.mask}};
        want = {e.clk, e.tick, e.ack} & {3{e.mask}};
    endtask

    task automatic test_reset();
        logic [11:0] got, want;
        int n;
        bus.div_en    = '0;
        bus.div_ratio = '0;
        bus.sync_in   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.clk_out, bus.div_tick, bus.ratio_ack} !== 12'h000) begin
            failed++;
            $display("[TB] FAIL reset_assert outputs got %h want 000", {bus.clk_out, bus.div_tick, bus.ratio_ack});
        end
        @(posedge clk_in);
        #1;
        tests++;
        if ({bus.clk_out, bus.div_tick, bus.ratio_ack} !== 12'h000) begin
            failed++;
            $display("[TB] FAIL reset_hold outputs got %h want 000", {bus.clk_out, bus.div_tick, bus.ratio_ack});
        end
        #2 rst_n = 1'b1;
        sb.delete();
        for (int ch = 0; ch < CH_NUM; ch++) add_idle(ch, 0, 3);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL reset_idle cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_basic();
        logic [11:0] got, want;
        int n;
        do_reset();
        add_wave(0, 4, 0, 12, 1'b1);
        n = sb.size();
        set_ratio(0, 4);
        bus.div_en = 4'b0001;
        for (int c = 0; c < n; c++) begin
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL basic_div4 cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_odd();
        logic [11:0] got, want;
        int n;
        do_reset();
        add_wave(1, 5, 0, 10, 1'b1);
        n = sb.size();
        set_ratio(1, 5);
        bus.div_en = 4'b0010;
        for (int c = 0; c < n; c++) begin
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL odd_div5 cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
            if (ODD50) begin
                @(negedge clk_in);
                #1;
                tests++;
                if (bus.clk_out[1] !== ((c % 5) < 3)) begin
                    failed++;
                    $display("[TB] FAIL odd_negedge cyc %0d clk_out[1] got %b want %b", c, bus.clk_out[1], ((c % 5) < 3));
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [11:0] got, want;
        int n;
        do_reset();
        add_wave(2, 6, 0, 6, 1'b1);
        add_wave(2, 3, 6, 9, 1'b1);
        n = sb.size();
        set_ratio(2, 6);
        bus.div_en = 4'b0100;
        for (int c = 0; c < n; c++) begin
            if (c == 3) set_ratio(2, 3);
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL ratio_change cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_sync();
        logic [11:0] got, want;
        int n;
        do_reset();
        add_wave(0, 4, 0, 5, 1'b1);
        add_wave(3, 6, 0, 5, 1'b1);
        add_wave(0, 4, 5, 26, 1'b0);
        add_wave(3, 6, 5, 26, 1'b0);
        add_idle(1, 0, 31);
        n = sb.size();
        set_ratio(0, 4);
        set_ratio(1, 7);
        set_ratio(3, 6);
        bus.div_en = 4'b1001;
        for (int c = 0; c < n; c++) begin
            bus.sync_in = (c == 5);
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL sync_align cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
        bus.sync_in = 1'b0;
    endtask

    task automatic test_disable();
        logic [11:0] got, want;
        int n;
        do_reset();
        add_wave(0, 8, 0, 8, 1'b1);
        add_idle(0, 8, 4);
        n = sb.size();
        set_ratio(0, 8);
        bus.div_en = 4'b0001;
        for (int c = 0; c < n; c++) begin
            if (c == 2) bus.div_en = 4'b0000;
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL disable_finish cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_clamp();
        logic [11:0] got, want;
        int n;
        do_reset();
        add_wave(1, 2, 0, 257, 1'b0);
        add_wave(2, 2, 0, 257, 1'b0);
        add_wave(3, 255, 0, 257, 1'b1);
        n = sb.size();
        set_ratio(1, 0);
        set_ratio(2, 1);
        set_ratio(3, 255);
        bus.div_en = 4'b1110;
        for (int c = 0; c < n; c++) begin
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL clamp_and_max cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got, want;
        logic [1:0]  run_exp;
        int n;
        do_reset();
        set_ratio(0, 4);
        set_ratio(1, 5);
        bus.div_en = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_in);
            #1;
        end
        run_exp = {clk_exp(5, 0), clk_exp(4, 1)};
        tests++;
        if (bus.clk_out[1:0] !== run_exp) begin
            failed++;
            $display("[TB] FAIL reset_mid_prerun clk_out got %b want %b", bus.clk_out[1:0], run_exp);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.clk_out, bus.div_tick, bus.ratio_ack} !== 12'h000) begin
            failed++;
            $display("[TB] FAIL reset_mid_async outputs got %h want 000", {bus.clk_out, bus.div_tick, bus.ratio_ack});
        end
        @(posedge clk_in);
        #3 rst_n = 1'b1;
        add_wave(0, 4, 0, 8, 1'b1);
        add_wave(1, 5, 0, 8, 1'b1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            advance(got, want);
            tests++;
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL reset_mid_restart cyc %0d clk/tick/ack got %b want %b", c, got, want);
            end
        end
    endtask

    initial begin
        bus.div_en    = '0;
        bus.div_ratio = '0;
        bus.sync_in   = 1'b0;
        test_reset();
        test_basic();
        test_odd();
        test_ratio_change();
        test_sync();
        test_disable();
        test_clamp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel programmable clock divider. Successor to the fixed /2 /4 divider.
- CH_NUM independent channels, each with a runtime divide ratio, enable, period-end tick and glitch-free ratio update.
- A global sync input phase-aligns all channels.
- Sits after the DLL/PLL clock-source mux. Feeds divided clocks to downstream phase detectors and sampling logic.

Parameters:
- CH_NUM, 4, number of divider channels (1..16)
- DIV_W, 8, width of each channel's ratio field; max ratio 2^DIV_W-1

Ports:
- clk_in  input  1  source clock; all logic on posedge, plus negedge only under the optional feature
- rst_n  input  1  asynchronous active-low reset
- div_en  input  CH_NUM  per-channel enable
- div_ratio  input  CH_NUM*DIV_W  per-channel ratio N; channel k occupies bits [k*DIV_W +: DIV_W]
- sync_in  input  1  phase-align strobe, sampled on posedge
- clk_out  output  CH_NUM  divided clocks, registered
- div_tick  output  CH_NUM  one-cycle pulse in the last source cycle of each output period
- ratio_ack  output  CH_NUM  one-cycle pulse when a new ratio value is loaded into the shadow register

Behaviour:
- Interface: one clock, clk_in. Reset rst_n is asynchronous and active-low.
- Reset (async, any time, including mid-period): per channel cnt=0, active=0, shadow=2. All outputs (clk_out, div_tick, ratio_ack) go 0 immediately.
- Ratio clamp: N=0 or 1 is treated as 2. Effective N lies in 2..2^DIV_W-1.
- Per-channel state: IDLE (active=0) or RUN (active=1). Counter cnt is DIV_W bits. H = ceil(N/2) using the shadow ratio.
- IDLE, posedge with div_en=1:
  - Load shadow from clamped div_ratio; ratio_ack=1 if the value differs from the old shadow.
  - cnt=0, clk_out=1, go to RUN.
- IDLE, div_en=0: clk_out=0, cnt=0, hold.
- RUN, cnt<N-1: cnt++. clk_out=(cnt+1<H). div_tick=(cnt+1==N-1).
- RUN, cnt==N-1 (wrap edge):
  - If div_en=1: cnt=0, clk_out=1, shadow reloaded from div_ratio (ratio_ack as above).
  - If div_en=0: clk_out=0, go to IDLE.
  - Disable therefore always completes the current period; no runt pulses.
- div_ratio changes mid-period are ignored until the next wrap. The output never shows a partial period.
- Even N: high N/2 cycles, low N/2 cycles. Odd N: high (N+1)/2, low (N-1)/2, unless the optional feature is enabled.
- Latency: the first rising edge of clk_out is registered on the first posedge that samples div_en=1 while IDLE.
- sync_in=1 at posedge:
  - Every channel with div_en=1 (IDLE or RUN) executes the wrap/start action: cnt=0, clk_out=1, shadow reload.
  - Has priority over normal counting and over the wrap decision.
  - Channels with div_en=0 are unaffected; a RUN channel still finishes its period.
  - div_tick is not asserted on the sync edge.
- Channels are fully independent except for sync_in. Simultaneous enables start in phase.

Optional Feature:
- Macro: CLKDIV_ODD_DUTY50_EN.
- Defined: each channel adds a negedge flop that samples the posedge clk_out. For odd N, the output is the AND of the posedge and negedge flops, giving exactly N/2 source cycles high and N/2 low (50% duty). Even N behaviour is unchanged. The negedge flop also resets asynchronously to 0.
- Undefined: no negedge logic; odd N uses the (N+1)/2 high duty defined under Behaviour.

Test Plan:
- Reset, then div_en=4'b0001, ratio ch0=4 -> clk_out[0] reads 1,1,0,0 repeating; div_tick[0] high every 4th cycle, on the cycle before each rising edge; ratio_ack[0] pulses once.
- Ch1 ratio=5, feature undefined -> 3 high / 2 low; feature defined -> high 2.5 cycles, low 2.5 cycles. Period is 5 cycles in both cases.
- Ch2 running at ratio=6; change to 3 at cnt=2 -> current 6-cycle period completes; next period is 3 cycles; ratio_ack[2] pulses on the wrap edge only.
- Ch0=4, ch3=6 running; pulse sync_in -> both clk_out rise on the same edge with cnt=0; no div_tick on that edge; LCM alignment repeats every 12 cycles.
- Drop div_en[0] at cnt=1 of ratio=8 -> clk_out finishes the 8-cycle period, then holds 0. Ratio 0 and 1 -> behaves as ratio 2.
- Assert rst_n low mid-period asynchronously, between edges -> all outputs go 0 immediately. Release with div_en high -> restarts at cnt=0 with shadow reloaded.
